opl3_bus_writer: RTL and testbench
==================================

Name: opl3_bus_writer

Overview:
- Host-side front end for the OPL3 sequencer's register-write queue.
- Converts C64 I/O bus cycles (address port / data port, two register banks) into single-cycle {addr[1:0], din[7:0], wr} queue writes.
- The sequencer never returns status, so this block also emulates the OPL status register: Timer 1, Timer 2, flags and IRQ, driven by shadow copies of registers 0x02/0x03/0x04.
- Sits in the C64 clock domain, between the expansion-port decoder and the queue's write side.

Parameters:
- CLK_HZ, 50000000, frequency of clk in Hz.
- TICK_DIV, CLK_HZ/12500, clk cycles per 80 us Timer 1 tick.
- T2_PRESCALE, 4, Timer 1 ticks per Timer 2 tick (320 us).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_wr  in  1  I/O write strobe, level, may be held several cycles.
- bus_rd  in  1  I/O read strobe, level.
- bus_a  in  1  0 = address port, 1 = data port.
- bus_bank  in  1  0 = OPL3 array 0, 1 = array 1.
- bus_din  in  8  write data.
- bus_dout  out  8  read data (status register).
- q_addr  out  2  queue address, {bus_bank, bus_a} latched at the write edge.
- q_data  out  8  queue data.
- q_wr  out  1  one-cycle queue write pulse.

Behaviour:
- Reset values: bus_dout=0x00, q_addr=0, q_data=0, q_wr=0.
- Reset also clears the index shadow, T1/T2 preload (0x00), T1/T2 counters, start bits, mask bits, both flags and the tick prescalers.
- Reset asserted mid-operation aborts any pending pulse; q_wr is 0 in the cycle after reset.

Write path:
- The rising edge of bus_wr (registered compare against the previous cycle) produces exactly one q_wr pulse, one cycle after the edge.
- q_addr/q_data are latched from the bus in that same edge cycle and are held until the next write edge.
- A held bus_wr produces no further pulses.
- Every write is forwarded to the queue, whatever the bank or index.
- Address write with bank 0: index shadow <= bus_din.
- Address write with bank 1: index shadow is left unchanged.
- Data write with bank 0 and index 0x02: T1 preload <= bus_din.
- Data write with bank 0 and index 0x03: T2 preload <= bus_din.
- Data write with bank 0 and index 0x04, bit7 = 1: clears both flags; all other bits are ignored.
- Data write with bank 0 and index 0x04, bit7 = 0: mask1 <= bit6, mask2 <= bit5, start2 <= bit1, start1 <= bit0.
- A start bit going 0->1 loads the counter from its preload in the same cycle the register updates.
- A start bit going 1->0 freezes the counter; the flag is unaffected.

Timers:
- The 80 us prescaler runs continuously, counting 0..TICK_DIV-1, and emits tick1 on wrap.
- A second prescaler counts tick1 modulo T2_PRESCALE and emits tick2.
- On tick, a started counter increments by 1 (8-bit).
- At 0xFF + tick the counter reloads its preload. If its mask = 0, its flag is set; if mask = 1, the flag is not set but the reload still happens.
- Flag set and a 0x04 bit7 clear in the same cycle: the clear wins.
- Status byte = {flag1|flag2, flag1, flag2, 5'b00000}.

Read path:
- bus_rd with bus_a=0 and bank 0: bus_dout <= status (registered, one-cycle latency).
- Any other read: bus_dout <= 0xFF.
- Reads have no side effects.
- bus_wr and bus_rd both active: the write is processed; the read updates bus_dout normally.

Optional Feature:
- Macro OPL_BUS_WRITER_IRQ_EN.
- Defined: adds output port irq_n (1 bit, active low, registered) = ~(flag1|flag2); reset value 1.
- Undefined: no irq_n port; the status register is the only way to observe the timers.

Test Plan:
- Write 0x04 to address port, then 0x21 to data port, bank 0, each strobe held 5 cycles -> exactly two q_wr pulses: {q_addr=0, q_data=0x04}, then {q_addr=1, q_data=0x21}.
- Bank 1 address write 0x05, then data 0x01 -> q_addr 2 then 3; index shadow unchanged (a following bank-0 data write 0x80 still acts on index 0x04 if that was last set).
- Preload T1=0xFE, write 0x04 data 0x01 -> flag1 set after 2×4000 cycles (CLK_HZ=50 MHz); status read = 0xC0; counter reloads 0xFE.
- T2 preload 0xFF, start2, mask2=0 -> status = 0xA0 after 16000 cycles; write 0x04 data 0x80 -> status = 0x00.
- mask1=1 with start1 and T1 preload 0xFF -> flag1 never set over 20000 cycles; status stays 0x00.
- Assert reset while timers are running and a bus_wr is held -> outputs at reset values, no q_wr pulse on reset release until a new bus_wr edge.

Source files
------------

// File: rtl/opl3_bus_writer_if.sv
// Host bus / queue-write bundle for opl3_bus_writer.
//
// Handshake: the queue side has no ready. q_wr is a one-cycle valid pulse.
// q_addr/q_data are valid in the cycle q_wr is high. They stay stable until
// the next bus_wr rising edge, and the queue must accept the beat in that cycle.
// On the host side, bus_wr and bus_rd are level strobes. Only the rising edge
// of bus_wr counts as a write. bus_rd is re-sampled every cycle it is high.
interface opl3_bus_writer_if;
    logic       bus_wr;
    logic       bus_rd;
    logic       bus_a;
    logic       bus_bank;
    logic [7:0] bus_din;
    logic [7:0] bus_dout;
    logic [1:0] q_addr;
    logic [7:0] q_data;
    logic       q_wr;

    // Host / expansion-port decoder side
    modport master (
        output bus_wr, bus_rd, bus_a, bus_bank, bus_din,
        input  bus_dout, q_addr, q_data, q_wr
    );

    // opl3_bus_writer side
    modport slave (
        input  bus_wr, bus_rd, bus_a, bus_bank, bus_din,
        output bus_dout, q_addr, q_data, q_wr
    );
endinterface

// File: rtl/opl3_bus_writer.sv
// opl3_bus_writer: turns C64 I/O bus cycles into single-cycle queue writes.
// It also emulates the OPL status register (Timer 1 and Timer 2, the flags,
// and the IRQ summary) from shadow copies of registers 0x02, 0x03 and 0x04.
// Optional feature: define OPL_BUS_WRITER_IRQ_EN to add the active-low irq_n output.
module opl3_bus_writer #(
    parameter int CLK_HZ      = 50000000,
    parameter int TICK_DIV    = CLK_HZ / 12500,
    parameter int T2_PRESCALE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    opl3_bus_writer_if.slave     bus
`ifdef OPL_BUS_WRITER_IRQ_EN
    ,
    output logic                 irq_n
`endif
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (T2_PRESCALE > 1) ? $clog2(T2_PRESCALE) : 1;

    logic          wr_q;
    logic [7:0]    idx;
    logic [7:0]    pre1, pre2, cnt1, cnt2;
    logic          start1, start2, mask1, mask2, flag1, flag2;
    logic [TW-1:0] tick_cnt;
    logic [PW-1:0] t2_pre;

    logic       wr_edge, addr_wr0, data_wr0, reg04_wr, flag_clr, ctl_wr;
    logic       start1_nxt, start2_nxt, tick1, tick2, t1_ovf, t2_ovf;
    logic [7:0] status;

    // Decode the write edge and the timer events for this cycle
    always_comb begin
        wr_edge    = bus.bus_wr & ~wr_q;
        addr_wr0   = wr_edge & ~bus.bus_a & ~bus.bus_bank;
        data_wr0   = wr_edge &  bus.bus_a & ~bus.bus_bank;
        reg04_wr   = data_wr0 && (idx == 8'h04);
        flag_clr   = reg04_wr &  bus.bus_din[7];
        ctl_wr     = reg04_wr & ~bus.bus_din[7];
        start1_nxt = ctl_wr ? bus.bus_din[0] : start1;
        start2_nxt = ctl_wr ? bus.bus_din[1] : start2;
        tick1      = (tick_cnt == TW'(TICK_DIV - 1));
        tick2      = tick1 && (t2_pre == PW'(T2_PRESCALE - 1));
        // A counter that is being stopped in this cycle is already frozen
        t1_ovf     = start1 & start1_nxt & tick1 & (cnt1 == 8'hFF);
        t2_ovf     = start2 & start2_nxt & tick2 & (cnt2 == 8'hFF);
        status     = {flag1 | flag2, flag1, flag2, 5'b00000};
    end

    // Edge detector and queue beat. During reset the detector tracks bus_wr,
    // so a strobe held across reset release does not fire a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q       <= bus.bus_wr;
            bus.q_wr   <= 1'b0;
            bus.q_addr <= 2'd0;
            bus.q_data <= 8'h00;
        end else begin
            wr_q     <= bus.bus_wr;
            bus.q_wr <= wr_edge;
            if (wr_edge) begin
                bus.q_addr <= {bus.bus_bank, bus.bus_a};
                bus.q_data <= bus.bus_din;
            end
        end
    end

    // Register shadows: index, preloads, and the control fields of register 0x04
    always_ff @(posedge clk) begin
        if (reset) begin
            idx    <= 8'h00;
            pre1   <= 8'h00;
            pre2   <= 8'h00;
            start1 <= 1'b0;
            start2 <= 1'b0;
            mask1  <= 1'b0;
            mask2  <= 1'b0;
        end else begin
            if (addr_wr0) idx <= bus.bus_din;
            if (data_wr0 && idx == 8'h02) pre1 <= bus.bus_din;
            if (data_wr0 && idx == 8'h03) pre2 <= bus.bus_din;
            if (ctl_wr) begin
                mask1  <= bus.bus_din[6];
                mask2  <= bus.bus_din[5];
                start1 <= bus.bus_din[0];
                start2 <= bus.bus_din[1];
            end
        end
    end

    // Free-running 80 us prescaler and the tick1-to-tick2 divider
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            t2_pre   <= '0;
        end else begin
            tick_cnt <= tick1 ? '0 : tick_cnt + TW'(1);
            if (tick1) t2_pre <= tick2 ? '0 : t2_pre + PW'(1);
        end
    end

    // Timer counters: load on start, count on tick, reload from preload on overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt1 <= 8'h00;
            cnt2 <= 8'h00;
        end else begin
            if (start1_nxt & ~start1)                 cnt1 <= pre1;
            else if (start1 & start1_nxt & tick1)     cnt1 <= t1_ovf ? pre1 : cnt1 + 8'd1;
            if (start2_nxt & ~start2)                 cnt2 <= pre2;
            else if (start2 & start2_nxt & tick2)     cnt2 <= t2_ovf ? pre2 : cnt2 + 8'd1;
        end
    end

    // Overflow flags: set on unmasked overflow; a 0x04 bit7 clear wins over a set
    always_ff @(posedge clk) begin
        if (reset) begin
            flag1 <= 1'b0;
            flag2 <= 1'b0;
        end else if (flag_clr) begin
            flag1 <= 1'b0;
            flag2 <= 1'b0;
        end else begin
            if (t1_ovf & ~mask1) flag1 <= 1'b1;
            if (t2_ovf & ~mask2) flag2 <= 1'b1;
        end
    end

    // Registered read port: status on bank-0 address port, 0xFF elsewhere
    always_ff @(posedge clk) begin
        if (reset)           bus.bus_dout <= 8'h00;
        else if (bus.bus_rd) bus.bus_dout <= (!bus.bus_a && !bus.bus_bank) ? status : 8'hFF;
    end

`ifdef OPL_BUS_WRITER_IRQ_EN
    // Active-low interrupt summary of both flags
    always_ff @(posedge clk) begin
        if (reset) irq_n <= 1'b1;
        else       irq_n <= ~(flag1 | flag2);
    end
`endif
endmodule

// File: tb/tb_opl3_bus_writer.sv
// Directed testbench for opl3_bus_writer (default parameters: 50 MHz, TICK_DIV=4000).
module tb_opl3_bus_writer;
    localparam int TICK_DIV = 4000;

    logic clk;
    logic reset;
    opl3_bus_writer_if bus ();
`ifdef OPL_BUS_WRITER_IRQ_EN
    logic irq_n;
`endif

    opl3_bus_writer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef OPL_BUS_WRITER_IRQ_EN
        ,
        .irq_n (irq_n)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every q_wr beat is matched against the expected queue
    always @(negedge clk) begin
        if (bus.q_wr === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) check("q_wr_unexpected", 32'd1, 32'd0);
            else                   check("q_beat", {22'd0, bus.q_addr, bus.q_data}, {22'd0, exp_q.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic bank, input logic a, input logic [7:0] d, input int hold);
        int p0;
        p0 = pulse_cnt;
        exp_q.push_back({bank, a, d});
        @(negedge clk);
        bus.bus_bank = bank;
        bus.bus_a    = a;
        bus.bus_din  = d;
        bus.bus_wr   = 1'b1;
        @(negedge clk);
        check("q_wr_latency", {31'd0, bus.q_wr}, 32'd1);
        repeat (hold - 1) @(negedge clk);
        bus.bus_wr = 1'b0;
        repeat (2) @(negedge clk);
        check("q_wr_count", pulse_cnt - p0, 32'd1);
    endtask

    // Write register idx of bank 0 with value v
    task automatic reg_write(input logic [7:0] idx, input logic [7:0] v);
        bus_write(1'b0, 1'b0, idx, 2);
        bus_write(1'b0, 1'b1, v, 2);
    endtask

    task automatic bus_read(input logic bank, input logic a, output logic [7:0] d);
        @(negedge clk);
        bus.bus_bank = bank;
        bus.bus_a    = a;
        bus.bus_rd   = 1'b1;
        @(negedge clk);
        d = bus.bus_dout;
        bus.bus_rd = 1'b0;
    endtask

    // Poll status every cycle until it equals want; bounded by budget cycles
    task automatic poll_status(input logic [7:0] want, input int budget, output int at, output bit hit);
        int n;
        hit = 1'b0;
        at  = cyc;
        n   = 0;
        @(negedge clk);
        bus.bus_bank = 1'b0;
        bus.bus_a    = 1'b0;
        bus.bus_rd   = 1'b1;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.bus_dout === want) begin
                hit = 1'b1;
                at  = cyc;
            end
        end
        bus.bus_rd = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] rd;
    int t0, t_hit, t_hit2, nonzero;
    bit hit;

    initial begin
        reset = 1'b1;
        bus.bus_wr = 1'b0; bus.bus_rd = 1'b0; bus.bus_a = 1'b0;
        bus.bus_bank = 1'b0; bus.bus_din = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_dout",   {24'd0, bus.bus_dout}, 32'h00);
        check("rst_q_addr", {30'd0, bus.q_addr},   32'd0);
        check("rst_q_data", {24'd0, bus.q_data},   32'h00);
        check("rst_q_wr",   {31'd0, bus.q_wr},     32'd0);
`ifdef OPL_BUS_WRITER_IRQ_EN
        check("rst_irq_n",  {31'd0, irq_n},        32'd1);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Held strobes: one beat each
        bus_write(1'b0, 1'b0, 8'h04, 5);
        bus_write(1'b0, 1'b1, 8'h21, 5);
        check("hold_q_addr", {30'd0, bus.q_addr}, 32'd1);
        check("hold_q_data", {24'd0, bus.q_data}, 32'h21);
        reg_write(8'h04, 8'h00);                   // stop the timer started by 0x21

        // Non-status reads return 0xFF
        bus_read(1'b0, 1'b1, rd); check("rd_data_port", {24'd0, rd}, 32'hFF);
        bus_read(1'b1, 1'b0, rd); check("rd_bank1",     {24'd0, rd}, 32'hFF);
        bus_read(1'b0, 1'b0, rd); check("rd_status0",   {24'd0, rd}, 32'h00);

        // Timer 1: preload 0xFE, start -> flag after two ticks
        reg_write(8'h02, 8'hFE);
        reg_write(8'h04, 8'h01);
        t0 = cyc;
        poll_status(8'hC0, 2 * TICK_DIV + 100, t_hit, hit);
        check("t1_flag_hit", {31'd0, hit}, 32'd1);
        check("t1_window", {31'd0, (t_hit - t0 >= TICK_DIV - 8) && (t_hit - t0 <= 2 * TICK_DIV + 4)}, 32'd1);
        bus_write(1'b0, 1'b1, 8'h80, 2);           // clear flags, index still 0x04
        bus_read(1'b0, 1'b0, rd); check("t1_cleared", {24'd0, rd}, 32'h00);
        poll_status(8'hC0, 2 * TICK_DIV + 100, t_hit2, hit);
        check("t1_reload_hit", {31'd0, hit}, 32'd1);
        check("t1_reload_period", t_hit2 - t_hit, 2 * TICK_DIV);
        bus_write(1'b0, 1'b1, 8'h00, 2);           // stop
        bus_write(1'b0, 1'b1, 8'h80, 2);           // clear
        bus_read(1'b0, 1'b0, rd); check("t1_stop_clear", {24'd0, rd}, 32'h00);

        // Timer 2: preload 0xFF, start2 -> flag2 on the first tick2
        reg_write(8'h03, 8'hFF);
        reg_write(8'h04, 8'h02);
        t0 = cyc;
        poll_status(8'hA0, 4 * TICK_DIV + 100, t_hit, hit);
        check("t2_flag_hit", {31'd0, hit}, 32'd1);
        check("t2_window", {31'd0, (t_hit - t0 <= 4 * TICK_DIV + 4)}, 32'd1);

        // Bank 1 writes are forwarded but leave the index shadow at 0x04
        bus_write(1'b1, 1'b0, 8'h05, 2);
        bus_write(1'b1, 1'b1, 8'h01, 2);
        check("bank1_q_addr", {30'd0, bus.q_addr}, 32'd3);
        bus_read(1'b0, 1'b0, rd); check("bank1_no_effect", {24'd0, rd}, 32'hA0);
        bus_write(1'b0, 1'b1, 8'h80, 2);
        bus_read(1'b0, 1'b0, rd); check("t2_cleared", {24'd0, rd}, 32'h00);
        bus_write(1'b0, 1'b1, 8'h00, 2);

        // Masked Timer 1 overflows every tick but never raises a flag
        reg_write(8'h02, 8'hFF);
        reg_write(8'h04, 8'h41);
        nonzero = 0;
        @(negedge clk);
        bus.bus_a = 1'b0; bus.bus_bank = 1'b0; bus.bus_rd = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (bus.bus_dout !== 8'h00) nonzero++;
        end
        bus.bus_rd = 1'b0;
        check("mask1_no_flag", nonzero, 32'd0);

        // Reset in the middle of operation, with a strobe held across release
        bus_read(1'b0, 1'b1, rd);                  // leave 0xFF on bus_dout
        exp_q.push_back({1'b0, 1'b0, 8'h33});
        @(negedge clk);
        bus.bus_bank = 1'b0; bus.bus_a = 1'b0; bus.bus_din = 8'h33; bus.bus_wr = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_q_wr",   {31'd0, bus.q_wr},     32'd0);
        check("mid_rst_q_addr", {30'd0, bus.q_addr},   32'd0);
        check("mid_rst_q_data", {24'd0, bus.q_data},   32'h00);
        check("mid_rst_dout",   {24'd0, bus.bus_dout}, 32'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        t0 = pulse_cnt;
        repeat (5) @(negedge clk);
        check("rst_release_no_pulse", pulse_cnt - t0, 32'd0);
        bus.bus_wr = 1'b0;
        @(negedge clk);
        bus_write(1'b1, 1'b1, 8'h5A, 3);
        check("post_rst_q_addr", {30'd0, bus.q_addr}, 32'd3);
        bus_read(1'b0, 1'b0, rd); check("post_rst_status", {24'd0, rd}, 32'h00);

        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
